memoria_de_dados_parametrizada: RTL and testbench

MEMORIA_DE_DADOS_PARAMETRIZADA -- requirements
Module: memoria_de_dados_parametrizada

---
 rtl/memoria_de_dados_parametrizada.sv | 154 +++++++++++++++
 tb/tb_memoria_de_dados_parametrizada.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/memoria_de_dados_parametrizada.sv
`default_nettype none
// ============================================================================
// memoria_de_dados_parametrizada -- byte-addressed data memory with
// byte/half/word access, sign/zero-extended loads and post-reset clearing.
// Revision: 1.0
// ============================================================================
module memoria_de_dados_parametrizada #(
  parameter int MEM_SIZE       = 256,
  parameter int ADDR_WIDTH     = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [1:0]            tamanho,
  input  logic                  sinal,
  input  logic [ADDR_WIDTH-1:0] endereco,
  input  logic [31:0]           dado_Escrito,
  output logic                  pronto,
  output logic                  dadoValido,
  output logic [31:0]           dado_Lido,
  output logic                  erro
);

  localparam int                    CW    = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [CW-1:0]         LAST  = CW'(MEM_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(MEM_SIZE);

  typedef enum logic [0:0] {
    LIMPANDO = 1'b0,
    OCIOSO   = 1'b1
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [CW-1:0]           contador;
  logic [CW-1:0]           next_contador;
  logic                    clear_we;
  logic [31:0]             mem [MEM_SIZE];

  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [1:0]              lane;
  logic                    accept;
  logic                    req_err;
  logic                    write_en;
  logic                    read_en;
  logic [31:0]             rd_word;
  logic [31:0]             shifted;
  logic [31:0]             load_data;
  logic [3:0]              byte_en;
  logic [31:0]             wr_data;

  assign word_idx = endereco >> 2;
  assign lane     = endereco[1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if (CLEAR_ON_RESET) state <= LIMPANDO;
      else                state <= OCIOSO;
      contador <= '0;
    end else begin
      state    <= next_state;
      contador <= next_contador;
    end
  end

  // pronto is gated by reset so it drops the instant reset is asserted.
  always_comb begin
    next_state    = state;
    next_contador = contador;
    pronto        = 1'b0;
    clear_we      = 1'b0;
    case (state)
      LIMPANDO: begin
        clear_we = reset;
        if (contador == LAST) next_state = OCIOSO;
        else                  next_contador = contador + 1'b1;
      end
      OCIOSO:   pronto = reset;
      default:  next_state = OCIOSO;
    endcase
  end

  assign accept = pronto & (memRead | memWrite);

  always_comb begin
    req_err = (memRead & memWrite)
            | (tamanho == 2'b11)
            | ((tamanho == 2'b01) & endereco[0])
            | ((tamanho == 2'b10) & (lane != 2'b00))
            | (word_idx >= DEPTH);
  end

  assign write_en = accept & memWrite & ~req_err;
  assign read_en  = accept & memRead  & ~req_err;

  assign rd_word = mem[word_idx[CW-1:0]];
  assign shifted = rd_word >> {lane, 3'b000};

  always_comb begin
    load_data = rd_word;
    case (tamanho)
      2'b00:   load_data = {{24{sinal & shifted[7]}},  shifted[7:0]};
      2'b01:   load_data = {{16{sinal & shifted[15]}}, shifted[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    byte_en = 4'b1111;
    wr_data = dado_Escrito;
    case (tamanho)
      2'b00: begin
        byte_en = 4'b0001 << lane;
        wr_data = {4{dado_Escrito[7:0]}};
      end
      2'b01: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{dado_Escrito[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wr_data = dado_Escrito;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear_we) begin
      mem[contador] <= '0;
    end else if (write_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx[CW-1:0]][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dadoValido <= 1'b0;
      erro       <= 1'b0;
      dado_Lido  <= '0;
    end else begin
      dadoValido <= accept;
      erro       <= accept & req_err;
      if (accept & req_err) dado_Lido <= '0;
      else if (read_en)     dado_Lido <= load_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memoria_de_dados_parametrizada.sv
`default_nettype none
// Bench for memoria_de_dados_parametrizada: byte-array reference model checked
// every cycle, plus directed accesses with literal expected values.
module tb_memoria_de_dados_parametrizada;

  localparam int MS = 8;

  logic        clock        = 1'b0;
  logic        reset        = 1'b1;
  logic        memRead      = 1'b0;
  logic        memWrite     = 1'b0;
  logic [1:0]  tamanho      = 2'b00;
  logic        sinal        = 1'b0;
  logic [31:0] endereco     = '0;
  logic [31:0] dado_Escrito = '0;
  logic        pronto;
  logic        dadoValido;
  logic [31:0] dado_Lido;
  logic        erro;

  int tests = 0;
  int fails = 0;

  memoria_de_dados_parametrizada #(
    .MEM_SIZE(MS),
    .ADDR_WIDTH(32),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .memRead(memRead),
    .memWrite(memWrite),
    .tamanho(tamanho),
    .sinal(sinal),
    .endereco(endereco),
    .dado_Escrito(dado_Escrito),
    .pronto(pronto),
    .dadoValido(dadoValido),
    .dado_Lido(dado_Lido),
    .erro(erro)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: memory as a flat little-endian byte array.
  logic [7:0]  mbytes [4*MS];
  int          clear_left = 0;
  logic        exp_valid  = 1'b0;
  logic        exp_err    = 1'b0;
  logic [31:0] exp_data   = '0;
  int          n;
  longint      a;
  logic [31:0] v;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      clear_left = MS;
      exp_valid  = 1'b0;
      exp_err    = 1'b0;
      exp_data   = '0;
    end else if (clear_left > 0) begin
      for (int k = 0; k < 4; k++) mbytes[4*(MS-clear_left)+k] = 8'h00;
      clear_left = clear_left - 1;
      exp_valid  = 1'b0;
      exp_err    = 1'b0;
    end else if (memRead || memWrite) begin
      n = 1 << tamanho;
      a = endereco;
      exp_valid = 1'b1;
      exp_err = (memRead && memWrite) || (tamanho == 2'b11) || ((a % n) != 0) || ((a / 4) >= MS);
      if (exp_err) begin
        exp_data = '0;
      end else if (memWrite) begin
        for (int k = 0; k < n; k++) mbytes[int'(a)+k] = 8'((dado_Escrito >> (8*k)) & 32'hFF);
      end else begin
        v = '0;
        for (int k = 0; k < n; k++) v = v | (32'(mbytes[int'(a)+k]) << (8*k));
        if (sinal && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        exp_data = v;
      end
    end else begin
      exp_valid = 1'b0;
      exp_err   = 1'b0;
    end
  end

  always @(posedge clock) begin
    #1;
    chk("pronto",     {31'b0, pronto},     {31'b0, reset && (clear_left == 0)});
    chk("dadoValido", {31'b0, dadoValido}, {31'b0, exp_valid});
    chk("erro",       {31'b0, erro},       {31'b0, exp_err});
    chk("dado_Lido",  dado_Lido,           exp_data);
  end

  task automatic req(input bit rd, input bit wr, input logic [1:0] tam, input bit sg,
                     input logic [31:0] addr, input logic [31:0] d);
    @(negedge clock);
    memRead      = rd;
    memWrite     = wr;
    tamanho      = tam;
    sinal        = sg;
    endereco     = addr;
    dado_Escrito = d;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    @(negedge clock);
    memRead  = 1'b0;
    memWrite = 1'b0;
  endtask

  task automatic wait_ready(output int c);
    c = -1;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clock);
      #1;
      if (pronto) begin
        c = i;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    #1 reset = 1'b0;
    #2;
    chk("reset_pronto", {31'b0, pronto}, 32'd0);
    chk("reset_data", dado_Lido, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    wait_ready(c);
    chk("clear_cycles", c, 32'd8);

    for (int w = 0; w < MS; w++) begin
      req(1, 0, 2'b10, 0, 32'(4*w), 32'h0);
      chk("lw_cleared", dado_Lido, 32'h0000_0000);
    end

    req(0, 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF);
    chk("sw_valid", {31'b0, dadoValido}, 32'd1);
    req(1, 0, 2'b00, 1, 32'h13, 32'h0);
    chk("lb_13", dado_Lido, 32'hFFFF_FFDE);
    req(1, 0, 2'b00, 0, 32'h10, 32'h0);
    chk("lbu_10", dado_Lido, 32'h0000_00EF);
    req(1, 0, 2'b01, 1, 32'h12, 32'h0);
    chk("lh_12", dado_Lido, 32'hFFFF_DEAD);
    req(1, 0, 2'b01, 0, 32'h10, 32'h0);
    chk("lhu_10", dado_Lido, 32'h0000_BEEF);

    req(0, 1, 2'b00, 0, 32'h11, 32'h0000_0055);
    chk("sb_pulse", {31'b0, dadoValido}, 32'd1);
    req(1, 0, 2'b10, 0, 32'h10, 32'h0);
    chk("lw_after_sb_pulse", {31'b0, dadoValido}, 32'd1);
    chk("lw_after_sb", dado_Lido, 32'hDEAD_55EF);

    req(1, 0, 2'b10, 0, 32'h02, 32'h0);
    chk("err_lw_misal", {erro, dado_Lido[30:0]}, 32'h8000_0000);
    req(0, 1, 2'b01, 0, 32'h11, 32'h0000_FFFF);
    chk("err_sh_misal", {erro, dado_Lido[30:0]}, 32'h8000_0000);
    req(1, 0, 2'b11, 0, 32'h10, 32'h0);
    chk("err_size11", {erro, dado_Lido[30:0]}, 32'h8000_0000);
    req(1, 1, 2'b10, 0, 32'h10, 32'h0);
    chk("err_rdwr", {erro, dado_Lido[30:0]}, 32'h8000_0000);
    req(1, 0, 2'b10, 0, 32'h10, 32'h0);
    chk("lw_after_err", dado_Lido, 32'hDEAD_55EF);

    req(0, 1, 2'b10, 0, 32'(4*MS), 32'h1234_5678);
    chk("err_sw_oob", {31'b0, erro}, 32'd1);
    req(1, 0, 2'b10, 0, 32'(4*MS), 32'h0);
    chk("err_lw_oob", {31'b0, erro}, 32'd1);
    req(1, 0, 2'b10, 0, 32'h0, 32'h0);
    chk("no_alias_word0", dado_Lido, 32'h0000_0000);
    req(0, 1, 2'b10, 0, 32'(4*MS-4), 32'hCAFE_F00D);
    chk("sw_last_ok", {31'b0, erro}, 32'd0);
    req(1, 0, 2'b10, 0, 32'(4*MS-4), 32'h0);
    chk("lw_last", dado_Lido, 32'hCAFE_F00D);
    idle();

    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    wait_ready(c);
    chk("restart_clear_cycles", c, 32'd8);
    req(1, 0, 2'b10, 0, 32'h10, 32'h0);
    chk("lw_after_reclear", dado_Lido, 32'h0000_0000);

    req(0, 1, 2'b10, 0, 32'h1C, 32'h0BAD_C0DE);
    req(1, 0, 2'b10, 0, 32'h1C, 32'h0);
    chk("pending_read_data", dado_Lido, 32'h0BAD_C0DE);
    #2 reset = 1'b0;
    #1;
    chk("reset_drops_valid", {31'b0, dadoValido}, 32'd0);
    chk("reset_drops_data", dado_Lido, 32'h0);
    memRead = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    wait_ready(c);
    chk("clear_after_pending", c, 32'd8);
    idle();
    repeat (2) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
